// File: rtl/polytris_text_pkg.sv
// Shared constants, types and the double-dabble nibble adjust for the score panel.
package polytris_text_pkg;

    localparam logic [7:0] CHAR_BLANK       = 8'h0f;
    localparam logic [7:0] DIGIT_TOKEN_BASE = 8'h0a;
    localparam int         N_DIGITS         = 5;
    localparam int         CELL_W           = 8;
    localparam int         CELL_H           = 16;
    localparam int         BIN_W            = 17;

    typedef logic [N_DIGITS-1:0][3:0] bcd_digits_t;

    typedef enum logic {
        IDLE,
        SHIFT
    } conv_state_e;

    // Add 3 to every nibble >= 5 so the following left shift carries decimally.
    function automatic bcd_digits_t dd_adjust(input bcd_digits_t d);
        bcd_digits_t r;
        for (int i = 0; i < N_DIGITS; i++) begin
            r[i] = (d[i] >= 4'd5) ? d[i] + 4'd3 : d[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/score_panel_render_if.sv
// Pixel, character-map, font-ROM and score signals of the score panel renderer.
interface score_panel_render_if;
    import polytris_text_pkg::*;

    logic [9:0]       DrawX;
    logic [9:0]       DrawY;
    logic             FRAME_START;
    logic [BIN_W-1:0] SCORE;
    logic [5:0]       CHAR_ADDR;
    logic [7:0]       CHAR_DATA;
    logic [10:0]      FONT_ADDR;
    logic [7:0]       FONT_DATA;
    logic             PIXEL_ON;
    logic             IN_PANEL;
    logic             BCD_BUSY;

    modport master (
        output DrawX, DrawY, FRAME_START, SCORE, CHAR_DATA, FONT_DATA,
        input  CHAR_ADDR, FONT_ADDR, PIXEL_ON, IN_PANEL, BCD_BUSY
    );

    modport slave (
        input  DrawX, DrawY, FRAME_START, SCORE, CHAR_DATA, FONT_DATA,
        output CHAR_ADDR, FONT_ADDR, PIXEL_ON, IN_PANEL, BCD_BUSY
    );

endinterface

// File: rtl/score_bcd_conv.sv
// Latches the saturated score on START and converts it to BCD over 17 cycles;
// the visible digit register only changes when a conversion completes.
module score_bcd_conv
    import polytris_text_pkg::*;
#(
    parameter int SCORE_MAX = 99999
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             START,
    input  logic [BIN_W-1:0] BIN,
    output logic             BUSY,
    output bcd_digits_t      DIGITS
);

    localparam logic [BIN_W-1:0] SAT_VAL = BIN_W'(SCORE_MAX);

    conv_state_e      state_q;
    logic             busy_q;
    logic [4:0]       cnt_q;
    logic [BIN_W-1:0] bin_q;
    bcd_digits_t      acc_q, acc_d;
    bcd_digits_t      digits_q;
    logic [19:0]      adj_flat;
    logic             unused_adj_msb;

    assign adj_flat       = dd_adjust(acc_q);
    assign acc_d          = {adj_flat[18:0], bin_q[BIN_W-1]};
    // A 5-digit value <= 99999 never sets the top BCD bit before the final shift.
    assign unused_adj_msb = adj_flat[19];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            bin_q    <= '0;
            acc_q    <= '0;
            digits_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        bin_q   <= (BIN > SAT_VAL) ? SAT_VAL : BIN;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q <= acc_d;
                    bin_q <= {bin_q[BIN_W-2:0], 1'b0};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(BIN_W - 1)) begin
                        digits_q <= acc_d;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign BUSY   = busy_q;
    assign DIGITS = digits_q;

endmodule

// File: rtl/score_panel_render.sv
// Three-stage pixel pipeline: coordinates -> char cell, digit-token substitution
// -> font address, font row -> per-pixel foreground.
module score_panel_render
    import polytris_text_pkg::*;
#(
    parameter int PANEL_X   = 480,
    parameter int PANEL_Y   = 64,
    parameter int COLS      = 7,
    parameter int ROWS      = 6,
    parameter int SCORE_MAX = 99999
) (
    input logic                 Clk,
    input logic                 Reset,
    score_panel_render_if.slave bus
);

    localparam logic [9:0] X_LO = 10'(PANEL_X);
    localparam logic [9:0] X_HI = 10'(PANEL_X + COLS * CELL_W);
    localparam logic [9:0] Y_LO = 10'(PANEL_Y);
    localparam logic [9:0] Y_HI = 10'(PANEL_Y + ROWS * CELL_H);

    bcd_digits_t digits;
    logic        busy;

    score_bcd_conv #(.SCORE_MAX(SCORE_MAX)) u_conv (
        .Clk    (Clk),
        .Reset  (Reset),
        .START  (bus.FRAME_START),
        .BIN    (bus.SCORE),
        .BUSY   (busy),
        .DIGITS (digits)
    );

    // Offsets only need the bits that address inside the panel.
    logic [5:0] dx;
    logic [6:0] dy;
    logic       in_d;
    assign dx   = bus.DrawX[5:0] - X_LO[5:0];
    assign dy   = bus.DrawY[6:0] - Y_LO[6:0];
    assign in_d = (bus.DrawX >= X_LO) && (bus.DrawX < X_HI) &&
                  (bus.DrawY >= Y_LO) && (bus.DrawY < Y_HI);

    logic [3:1] vld_pipe_q;
    logic [2:0] col_q, row_q, xoff1_q, xoff2_q, xoff3_q;
    logic [3:0] yoff1_q;
    logic [10:0] font_addr_q;
    logic       blank2_q, blank3_q;

    // Token 0x0a..0x0e maps to digit index 0..4 via the low three bits.
    logic       is_tok;
    logic [2:0] tok_idx;
    logic [6:0] code;
    assign is_tok  = (bus.CHAR_DATA >= DIGIT_TOKEN_BASE) && (bus.CHAR_DATA < CHAR_BLANK);
    assign tok_idx = bus.CHAR_DATA[2:0] - 3'd2;
    assign code    = is_tok ? (7'h30 + {3'b000, digits[tok_idx]}) : bus.CHAR_DATA[6:0];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vld_pipe_q  <= '0;
            col_q       <= '0;
            row_q       <= '0;
            xoff1_q     <= '0;
            yoff1_q     <= '0;
            font_addr_q <= '0;
            blank2_q    <= 1'b0;
            xoff2_q     <= '0;
            blank3_q    <= 1'b0;
            xoff3_q     <= '0;
        end else begin
            vld_pipe_q  <= {vld_pipe_q[2:1], in_d};
            col_q       <= dx[5:3];
            row_q       <= dy[6:4];
            xoff1_q     <= dx[2:0];
            yoff1_q     <= dy[3:0];
            font_addr_q <= {code, yoff1_q};
            blank2_q    <= (bus.CHAR_DATA == CHAR_BLANK);
            xoff2_q     <= xoff1_q;
            blank3_q    <= blank2_q;
            xoff3_q     <= xoff2_q;
        end
    end

    assign bus.CHAR_ADDR = vld_pipe_q[1] ? (6'(row_q) * 6'(COLS) + 6'(col_q)) : 6'd0;
    assign bus.FONT_ADDR = font_addr_q;
    // Stage-3 controls are registered in step with the synchronous ROM so the
    // selected font bit lands in the same cycle as IN_PANEL.
    assign bus.PIXEL_ON  = bus.FONT_DATA[3'd7 - xoff3_q] & ~blank3_q & vld_pipe_q[3];
    assign bus.IN_PANEL  = vld_pipe_q[3];
    assign bus.BCD_BUSY  = busy;

endmodule

// File: tb/tb_score_panel_render.sv
// Directed checks of panel geometry, token substitution, blanking and BCD conversion.
module tb_score_panel_render;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    score_panel_render_if bus();

    score_panel_render u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    logic [7:0] charmap [0:63];
    logic [7:0] font_val = 8'h00;

    assign bus.CHAR_DATA = charmap[bus.CHAR_ADDR];
    always @(posedge Clk) bus.FONT_DATA <= font_val;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic put_pixel(input int x, input int y);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
    endtask

    // Present a pixel and return FONT_ADDR two cycles later.
    task automatic read_fa(input int x, input int y, output logic [10:0] fa);
        put_pixel(x, y);
        tick;
        tick;
        fa = bus.FONT_ADDR;
    endtask

    task automatic pulse_start(input logic [16:0] score);
        bus.SCORE = score;
        bus.FRAME_START = 1'b1;
        tick;
        bus.FRAME_START = 1'b0;
    endtask

    // Expected FONT_ADDR for display cell c (0 = most significant digit).
    function automatic logic [10:0] exp_fa(input int val, input int c, input int yoff);
        int p, d;
        p = 1;
        for (int k = 0; k < 4 - c; k++) p = p * 10;
        d = (val / p) % 10;
        return 11'(((48 + d) << 4) + yoff);
    endfunction

    task automatic test_reset;
        logic [10:0] fa;
        Reset = 1'b1;
        bus.FRAME_START = 1'b0;
        bus.SCORE = 17'd0;
        put_pixel(480, 64);
        tick; tick; tick;
        n_checks++; if (bus.CHAR_ADDR !== 6'd0) begin n_fail++; $display("FAIL reset_char_addr got %0d want 0", bus.CHAR_ADDR); end
        n_checks++; if (bus.FONT_ADDR !== 11'd0) begin n_fail++; $display("FAIL reset_font_addr got %h want 0", bus.FONT_ADDR); end
        n_checks++; if (bus.PIXEL_ON !== 1'b0) begin n_fail++; $display("FAIL reset_pixel_on got %b want 0", bus.PIXEL_ON); end
        n_checks++; if (bus.IN_PANEL !== 1'b0) begin n_fail++; $display("FAIL reset_in_panel got %b want 0", bus.IN_PANEL); end
        n_checks++; if (bus.BCD_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.BCD_BUSY); end
        Reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            read_fa(480 + 8 * c, 67, fa);
            n_checks++; if (fa !== 11'h303) begin n_fail++; $display("FAIL reset_digit%0d got %h want 303", c, fa); end
        end
    endtask

    task automatic test_bcd_12345;
        int busy_cnt;
        logic [10:0] fa;
        pulse_start(17'd12345);
        busy_cnt = 0;
        for (int i = 0; i < 40 && bus.BCD_BUSY === 1'b1; i++) begin
            busy_cnt++;
            tick;
        end
        n_checks++; if (busy_cnt != 17) begin n_fail++; $display("FAIL bcd_busy_len got %0d want 17", busy_cnt); end
        for (int c = 0; c < 5; c++) begin
            read_fa(480 + 8 * c, 67, fa);
            n_checks++; if (fa !== exp_fa(12345, c, 3)) begin n_fail++; $display("FAIL digits12345_cell%0d got %h want %h", c, fa, exp_fa(12345, c, 3)); end
        end
        read_fa(480 + 40, 67, fa);
        n_checks++; if (fa !== 11'h353) begin n_fail++; $display("FAIL token0_font_addr got %h want 353", fa); end
    endtask

    task automatic test_saturate_restart;
        int busy_cnt;
        logic [10:0] fa;
        pulse_start(17'h1FFFF);
        busy_cnt = 0;
        for (int i = 0; i < 40 && bus.BCD_BUSY === 1'b1; i++) begin
            busy_cnt++;
            bus.FRAME_START = (busy_cnt == 6) || (busy_cnt == 17);
            tick;
            bus.FRAME_START = 1'b0;
        end
        n_checks++; if (busy_cnt != 17) begin n_fail++; $display("FAIL sat_busy_len got %0d want 17", busy_cnt); end
        tick;
        n_checks++; if (bus.BCD_BUSY !== 1'b0) begin n_fail++; $display("FAIL sat_no_restart got %b want 0", bus.BCD_BUSY); end
        for (int c = 0; c < 5; c++) begin
            read_fa(480 + 8 * c, 67, fa);
            n_checks++; if (fa !== 11'h393) begin n_fail++; $display("FAIL digits99999_cell%0d got %h want 393", c, fa); end
        end
    endtask

    task automatic test_reset_mid;
        int busy_cnt;
        logic [10:0] fa;
        pulse_start(17'd54321);
        for (int i = 0; i < 7; i++) tick;
        Reset = 1'b1;
        tick;
        n_checks++; if (bus.BCD_BUSY !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", bus.BCD_BUSY); end
        Reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            read_fa(480 + 8 * c, 67, fa);
            n_checks++; if (fa !== 11'h303) begin n_fail++; $display("FAIL midreset_cell%0d got %h want 303", c, fa); end
        end
        pulse_start(17'd42);
        busy_cnt = 0;
        for (int i = 0; i < 40 && bus.BCD_BUSY === 1'b1; i++) begin
            busy_cnt++;
            tick;
        end
        n_checks++; if (busy_cnt != 17) begin n_fail++; $display("FAIL busy42_len got %0d want 17", busy_cnt); end
        for (int c = 0; c < 5; c++) begin
            read_fa(480 + 8 * c, 67, fa);
            n_checks++; if (fa !== exp_fa(42, c, 3)) begin n_fail++; $display("FAIL digits00042_cell%0d got %h want %h", c, fa, exp_fa(42, c, 3)); end
        end
    endtask

    task automatic test_geometry;
        int          xs [7] = '{479, 480, 535, 536, 500, 500, 506};
        int          ys [7] = '{100,  64, 159, 100,  63, 160, 101};
        logic [5:0]  ea [7] = '{6'd0, 6'd0, 6'd41, 6'd0, 6'd0, 6'd0, 6'd17};
        logic        ei [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 7; k++) begin
            put_pixel(xs[k], ys[k]);
            tick;
            n_checks++; if (bus.CHAR_ADDR !== ea[k]) begin n_fail++; $display("FAIL geom%0d_char_addr got %0d want %0d", k, bus.CHAR_ADDR, ea[k]); end
            tick;
            tick;
            n_checks++; if (bus.IN_PANEL !== ei[k]) begin n_fail++; $display("FAIL geom%0d_in_panel got %b want %b", k, bus.IN_PANEL, ei[k]); end
        end
    endtask

    task automatic test_blank;
        font_val = 8'hFF;
        charmap[17] = 8'h0f;
        charmap[18] = 8'h41;
        put_pixel(506, 101);
        tick; tick; tick;
        n_checks++; if (bus.PIXEL_ON !== 1'b0) begin n_fail++; $display("FAIL blank_pixel got %b want 0", bus.PIXEL_ON); end
        n_checks++; if (bus.IN_PANEL !== 1'b1) begin n_fail++; $display("FAIL blank_in_panel got %b want 1", bus.IN_PANEL); end
        put_pixel(514, 101);
        tick; tick; tick;
        n_checks++; if (bus.PIXEL_ON !== 1'b1) begin n_fail++; $display("FAIL glyph_pixel got %b want 1", bus.PIXEL_ON); end
        put_pixel(479, 101);
        tick; tick; tick;
        n_checks++; if (bus.PIXEL_ON !== 1'b0) begin n_fail++; $display("FAIL outside_pixel got %b want 0", bus.PIXEL_ON); end
    endtask

    task automatic test_back_to_back;
        logic exp_on;
        font_val = 8'h80;
        charmap[8] = 8'h50;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) put_pixel(488 + i, 85);
            else       put_pixel(0, 0);
            tick;
            if (i >= 1 && i <= 8) begin
                n_checks++; if (bus.FONT_ADDR !== 11'h505) begin n_fail++; $display("FAIL b2b_font_addr_x%0d got %h want 505", i - 1, bus.FONT_ADDR); end
            end
            if (i >= 2) begin
                exp_on = (i == 2);
                n_checks++; if (bus.PIXEL_ON !== exp_on) begin n_fail++; $display("FAIL b2b_pixel_x%0d got %b want %b", i - 2, bus.PIXEL_ON, exp_on); end
                n_checks++; if (bus.IN_PANEL !== 1'b1) begin n_fail++; $display("FAIL b2b_in_panel_x%0d got %b want 1", i - 2, bus.IN_PANEL); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) charmap[i] = 8'h20;
        for (int c = 0; c < 5; c++) charmap[c] = 8'(8'h0e - c);
        charmap[5] = 8'h0a;
        bus.DrawX = '0;
        bus.DrawY = '0;
        bus.FRAME_START = 1'b0;
        bus.SCORE = '0;
        test_reset;
        test_bcd_12345;
        test_saturate_restart;
        test_reset_mid;
        test_geometry;
        test_blank;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
